acs_resp: RTL
=============

# acs_resp

Memory-side responder for the CPU data-access port (`acs_*`): it serves the loads and stores the core issues each cycle. Backing storage is a word-organised data RAM plus a small MMIO page. The page holds a free-running cycle counter and a console transmit FIFO that drains over a valid/ready byte stream. The block sits beside `cpu` at top level, with `acs_*` wired directly between them.

## Interface
- `XLEN`, 64, data/address width (32 or 64)
- `RAM_BASE`, 0x8000_0000, byte address of RAM word 0
- `RAM_WORDS`, 4096, RAM depth in XLEN-bit words (power of 2)
- `MMIO_BASE`, 0xA000_0000, byte address of MMIO page (4 KiB)
- `FIFO_DEPTH`, 8, console FIFO entries (power of 2, ≥2)

Ports:
- `clk`  in  1  clock
- `rst`  in  1  reset; one clock, synchronous, active-high
- `acs_en`  in  1  access valid this cycle
- `acs_wr`  in  1  1 = store, 0 = load
- `acs_bytes`  in  XLEN/8  size mask, LSB-justified (0x01, 0x03, 0x0F, 0xFF)
- `acs_addr`  in  XLEN  byte address
- `acs_wdata`  in  XLEN  store data, LSB-justified
- `acs_rdata`  out  XLEN  load data, LSB-justified, combinational
- `acs_err`  out  1  registered pulse: previous-cycle access was unmapped or misaligned
- `con_valid`  out  1  console byte available
- `con_data`  out  8  console byte (FIFO head)
- `con_ready`  in  1  sink accepts byte

## Operation
- Byte offset `off = acs_addr[log2(XLEN/8)-1:0]`, word index taken from the bits above it.
- Misaligned access: the mask shifted left by `off` overflows the word. Loads return 0, stores are dropped, `acs_err` is raised.
- RAM hit when `RAM_BASE ≤ addr < RAM_BASE + RAM_WORDS*XLEN/8`.
  - Load: `acs_rdata = (word >> 8*off) & expand(acs_bytes)`.
  - Store: byte lanes `acs_bytes << off` are written with `acs_wdata << 8*off`. Unmasked lanes are preserved.
- MMIO page, byte offsets; only full-XLEN aligned accesses are legal, other sizes set `acs_err`:
  - +0x00 `mtime`: 64-bit counter, +1 every cycle, wraps 2^64−1→0. Read-only, writes ignored. For XLEN=32, +0x00 returns the low half and +0x04 the high half.
  - +0x08 `txdata`: write pushes `acs_wdata[7:0]` to the FIFO. Reads return 0.
  - +0x10 `status`: [7:0] FIFO count, [8] full, [9] empty, [10] overflow (sticky). Writing with bit10=1 clears overflow (W1C); other bits are read-only.
- Push while full (and no pop the same cycle): the byte is dropped and overflow is set.
- Any other address with `acs_en`: loads return 0, stores are dropped, `acs_err` is raised.
- `acs_en=0`: `acs_rdata = 0`, no state change except the counter and FIFO pop.
- FIFO head drives `con_data`. `con_valid = !empty`. A pop occurs on an edge with `con_valid & con_ready`.

## Timing
- Reset values:
  - `mtime` = 0, FIFO count 0, overflow 0.
  - `con_valid` = 0, `con_data` = 0, `acs_err` = 0.
  - RAM contents are not reset.
- Loads have zero latency: `acs_rdata` is valid in the same cycle as `acs_addr`, which the single-cycle core requires.
- Stores, pushes and W1C take effect at the rising edge that ends the access cycle. A load of the same address in the next cycle sees the new data.
- A load of `mtime` returns the value held in that cycle, i.e. pre-increment.
- `acs_err` is asserted in the cycle after the offending access, for exactly one cycle.
- Simultaneous push and pop when full: both occur, count is unchanged, no overflow.
- Simultaneous push and pop when empty: the pop is impossible (`con_valid=0`), the push lands, and `con_valid` rises the next cycle.
- Overflow-set and W1C in the same cycle: set wins, overflow stays 1.
- Status read in the same cycle as a push or pop returns the pre-edge count.
- `rst` asserted mid-stream: the FIFO flushes at that edge, any pending store in that cycle is dropped, and `con_valid` is 0 the next cycle.

## Test plan
- Byte-lane store, XLEN=64. Store 0x1122334455667788 (mask 0xFF) at 0x8000_0000, then store 0xAB (mask 0x01) at 0x8000_0003. Full load returns 0x11223344AB667788. A half load (mask 0x03) at 0x8000_0006 returns 0x1122.
- Misaligned and unmapped. Word load (mask 0x0F) at 0x8000_0006 returns 0 and `acs_err` pulses one cycle later. A store to 0x9000_0000 is dropped, `acs_err` pulses, and RAM is unchanged.
- Counter. After `rst` deasserts, a read of +0x00 in the 10th post-reset cycle returns 9. A write of 0xFFFF to +0x00 does not change the count progression.
- FIFO fill/overflow. Hold `con_ready=0` and push 9 bytes 0x41..0x49. Status reads count=8, full=1, overflow=1. W1C with 0x400 clears overflow only. Raise `con_ready` and observe 0x41..0x48 on consecutive cycles, then `con_valid=0`.
- Push+pop when full. With the FIFO full, issue a push of 0x5A while `con_ready=1`. Count stays 8, overflow stays 0, and 0x5A is emitted last.
- Reset mid-drain. Assert `rst` while 3 bytes are queued. The next cycle shows `con_valid=0` and status count=0.

Source files
------------

// File: rtl/acs_resp.sv
// acs_resp: zero-latency load/store responder over a word RAM and an MMIO page
// holding a free-running mtime counter and a console transmit FIFO.
module acs_resp #(
   parameter int          XLEN       = 64,
   parameter logic [63:0] RAM_BASE   = 64'h8000_0000,
   parameter int          RAM_WORDS  = 4096,
   parameter logic [63:0] MMIO_BASE  = 64'hA000_0000,
   parameter int          FIFO_DEPTH = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              acs_en,
   input  logic              acs_wr,
   input  logic [XLEN/8-1:0] acs_bytes,
   input  logic [XLEN-1:0]   acs_addr,
   input  logic [XLEN-1:0]   acs_wdata,
   output logic [XLEN-1:0]   acs_rdata,
   output logic              acs_err,
   output logic              con_valid,
   output logic [7:0]        con_data,
   input  logic              con_ready
);
   localparam int NB = XLEN / 8;
   localparam int OW = $clog2(NB);
   localparam int AW = $clog2(RAM_WORDS);
   localparam int PW = $clog2(FIFO_DEPTH);
   localparam logic [64:0] RAM_END  = {1'b0, RAM_BASE} + 65'(RAM_WORDS * NB);
   localparam logic [64:0] MMIO_END = {1'b0, MMIO_BASE} + 65'd4096;

   logic [XLEN-1:0] ram [RAM_WORDS];
   logic [7:0]      fifo [FIFO_DEPTH];
   logic [63:0]     mtime;
   logic [PW:0]     cnt;
   logic [PW-1:0]   rp, wp;
   logic            ovf;

   logic [64:0]     a65;
   logic [OW-1:0]   off;
   logic [2*NB-1:0] lanes_x;
   logic [NB-1:0]   lanes;
   logic [XLEN-1:0] bmask, wsh, stat;
   logic [11:0]     moff;
   logic [AW-1:0]   ridx;
   logic misal, ram_hit, mmio_hit, is_time, is_tx, is_st, bad, ok;
   logic empty, full, push, pop, acc, w1c;

   assign a65      = 65'(acs_addr);
   assign off      = acs_addr[OW-1:0];
   // a lane shifted past the top of the word marks a misaligned access
   assign lanes_x  = {{NB{1'b0}}, acs_bytes} << off;
   assign lanes    = lanes_x[NB-1:0];
   assign misal    = |lanes_x[2*NB-1:NB];
   assign ram_hit  = a65 >= {1'b0, RAM_BASE} && a65 < RAM_END;
   assign mmio_hit = a65 >= {1'b0, MMIO_BASE} && a65 < MMIO_END;
   assign ridx     = AW'((acs_addr - XLEN'(RAM_BASE)) >> OW);
   assign moff     = 12'(acs_addr - XLEN'(MMIO_BASE));
   assign is_time  = moff == 12'h0 || (XLEN == 32 && moff == 12'h4);
   assign is_tx    = moff == 12'h8;
   assign is_st    = moff == 12'h10;
   assign bad      = misal || !(ram_hit || (mmio_hit && &acs_bytes && (is_time || is_tx || is_st)));
   assign ok       = acs_en && !bad;
   assign empty    = cnt == '0;
   assign full     = cnt == (PW+1)'(FIFO_DEPTH);
   assign pop      = !empty && con_ready;
   assign push     = ok && acs_wr && mmio_hit && is_tx;
   assign acc      = push && (!full || pop);
   assign w1c      = ok && acs_wr && mmio_hit && is_st && acs_wdata[10];
   assign wsh      = acs_wdata << {off, 3'b0};
   assign stat     = XLEN'({ovf, empty, full, 8'(cnt)});
   assign con_valid = !empty;
   assign con_data  = empty ? 8'h0 : fifo[rp];

   always_comb begin
      bmask = '0;
      for (int i = 0; i < NB; i++) bmask[8*i +: 8] = {8{acs_bytes[i]}};
   end

   always_comb begin
      acs_rdata = '0;
      if (acs_en && !acs_wr && !bad)
         acs_rdata = ram_hit ? (ram[ridx] >> {off, 3'b0}) & bmask
                   : is_time ? XLEN'(mtime >> {moff[2], 5'b0})
                   : is_st ? stat : '0;
   end

   always_ff @(posedge clk) begin
      if (!rst && ok && acs_wr && ram_hit)
         for (int i = 0; i < NB; i++) if (lanes[i]) ram[ridx][8*i +: 8] <= wsh[8*i +: 8];
      if (!rst && acc) fifo[wp] <= acs_wdata[7:0];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         mtime   <= '0;
         cnt     <= '0;
         rp      <= '0;
         wp      <= '0;
         ovf     <= 1'b0;
         acs_err <= 1'b0;
      end else begin
         mtime   <= mtime + 64'd1;
         acs_err <= acs_en && bad;
         if (acc) wp <= wp + 1'b1;
         if (pop) rp <= rp + 1'b1;
         cnt <= cnt + {{PW{1'b0}}, acc} - {{PW{1'b0}}, pop};
         if (push && full && !pop) ovf <= 1'b1;
         else if (w1c) ovf <= 1'b0;
      end
   end
endmodule
